// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the LSU-side and memory-side request/response
// signals of mem_arbiter.
//   consumer_*  : per-LSU read/write request ports (packed, slot i at [i*W +: W])
//   mem_*       : single shared external data-memory channel
// Modports:
//   master : the arbiter (drives memory requests and LSU responses)
//   slave  : the environment (LSUs and memory)
interface mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_address;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;
    logic                               mem_write_valid;
    logic [ADDR_BITS-1:0]               mem_write_address;
    logic [DATA_BITS-1:0]               mem_write_data;
    logic                               mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external data-memory channel between NUM_CONSUMERS
// LSUs. One transaction at a time is granted round-robin, forwarded to memory,
// and its response relayed back to the granted LSU. All outputs are registered.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous reset, active low
//   bus     : mem_arbiter_if.master (LSU request/response + memory channel)
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);
    localparam int GRANT_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELAY
    } state_t;

    state_t                             state_q, state_d;
    logic [GRANT_BITS-1:0]              grant_q, grant_d;
    logic [GRANT_BITS-1:0]              rr_ptr_q, rr_ptr_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
    logic                               mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

    logic                               found;
    logic [GRANT_BITS-1:0]              win;
    int unsigned                        idx;

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        rr_ptr_d            = rr_ptr_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;
        found               = 1'b0;
        win                 = '0;
        idx                 = 0;

        unique case (state_q)
            IDLE: begin
                // Scan starting at rr_ptr; first requester in cyclic order wins.
                for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = (32'(rr_ptr_q) + k) % NUM_CONSUMERS;
                    if (!found && (bus.consumer_read_valid[idx] || bus.consumer_write_valid[idx])) begin
                        found = 1'b1;
                        win   = GRANT_BITS'(idx);
                    end
                end
                if (found) begin
                    grant_d = win;
                    // A consumer asserting both read and write is served its read first.
                    if (bus.consumer_read_valid[win]) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = bus.consumer_read_address[win*ADDR_BITS +: ADDR_BITS];
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = bus.consumer_write_address[win*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_d    = bus.consumer_write_data[win*DATA_BITS +: DATA_BITS];
                        state_d             = WRITE_WAIT;
                    end
                end
            end

            READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    mem_read_valid_d                                = 1'b0;
                    read_ready_d[grant_q]                           = 1'b1;
                    read_data_d[grant_q*DATA_BITS +: DATA_BITS]     = bus.mem_read_data;
                    state_d                                         = RELAY;
                end
            end

            WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    mem_write_valid_d      = 1'b0;
                    write_ready_d[grant_q] = 1'b1;
                    state_d                = RELAY;
                end
            end

            RELAY: begin
                // Hold the response until the granted LSU has dropped both requests.
                if (!bus.consumer_read_valid[grant_q] && !bus.consumer_write_valid[grant_q]) begin
                    read_ready_d[grant_q]  = 1'b0;
                    write_ready_d[grant_q] = 1'b0;
                    rr_ptr_d               = (grant_q == GRANT_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
                    state_d                = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            rr_ptr_q            <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            rr_ptr_q            <= rr_ptr_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
        end
    end

    assign bus.mem_read_valid       = mem_read_valid_q;
    assign bus.mem_read_address     = mem_read_address_q;
    assign bus.mem_write_valid      = mem_write_valid_q;
    assign bus.mem_write_address    = mem_write_address_q;
    assign bus.mem_write_data       = mem_write_data_q;
    assign bus.consumer_read_ready  = read_ready_q;
    assign bus.consumer_write_ready = write_ready_q;
    assign bus.consumer_read_data   = read_data_q;
endmodule
